pipe_run_ctrl: RTL and testbench
================================

// Module: pipe_run_ctrl
// PURPOSE
//  Run/step/halt sequencer for the 5-stage pipelined CPU datapath.
//  Gates IF (fetch_en) and the whole pipeline (pipe_en; datapath turn_off = ~pipe_en).
//  Stops on host halt request, PC breakpoint or HALT opcode in decode, then drains EX/MEM/WB.
//  Counts cycles and fetched instructions for the bench and debug readout.
// PARAMETERS
//  PC_W      32     PC / breakpoint address width
//  CNT_W     32     cycle and instruction counter width
//  OP_W      6      opcode width (decode stage)
//  HALT_OP   6'h3F  opcode that halts the machine
//  DRAIN_CYC 3      non-stalled cycles needed to retire in-flight instructions
// PORTS
//  clk        in   1      clock, rising edge
//  clear      in   1      reset, synchronous, active-high
//  start      in   1      run (IDLE: fresh run; HALTED: resume)
//  step       in   1      fetch exactly one instruction, then drain and halt
//  halt_req   in   1      host halt request
//  bp_en      in   1      breakpoint enable
//  bp_addr    in   PC_W   breakpoint PC
//  pc         in   PC_W   current fetch PC
//  op_code    in   OP_W   opcode in decode stage
//  stall      in   1      hazard stall from forwarding/stall unit
//  fetch_en   out  1      IF may fetch/advance PC (combinational)
//  pipe_en    out  1      pipeline registers advance (registered)
//  kill_if    out  1      1-cycle squash of IF/ID buffer (registered)
//  halted     out  1      state==HALTED
//  state      out  3      FSM state
//  halt_cause out  2      00 none, 01 host, 10 breakpoint, 11 HALT_OP
//  cycle_cnt  out  CNT_W  cycles spent in RUN/STEP/DRAIN
//  instr_cnt  out  CNT_W  instructions fetched
// BEHAVIOUR
//  Reset: state=IDLE, pipe_en=0, kill_if=0, halt_cause=0, counters=0, bp_skip=0.
//  Clear is sampled every edge; mid-run it forces IDLE next edge, no drain.
//  States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
//  IDLE: start -> RUN, counters cleared; else step -> STEP, counters cleared.
//   start wins over simultaneous step; halt_req ignored.
//  RUN: halt check, priority halt_req > bp_hit > halt_op:
//   bp_hit = bp_en & pc==bp_addr & ~bp_skip; halt_op = op_code==HALT_OP & ~stall.
//   Any hit -> DRAIN; halt_cause latched. halt_op also pulses kill_if next cycle.
//   step ignored.
//  STEP: fetch_en=1 until the first non-stalled cycle, then DRAIN, halt_cause=00.
//   halt_req in STEP -> DRAIN with cause 01 if fetch not yet done.
//  DRAIN: fetch_en=0, pipe_en=1; drain count increments on ~stall.
//   At DRAIN_CYC -> HALTED; count reset on entry; halt_req/step/start ignored.
//  HALTED: pipe_en=0. start -> RUN, counters kept, bp_skip=1; step -> STEP.
//   halt_cause holds until the next RUN/STEP entry, then clears.
//  bp_skip clears after the first non-stalled RUN cycle.
//   Resuming at a breakpoint PC then moves past it.
//  fetch_en = (RUN & ~halt_req & ~bp_hit) | (STEP & ~step_done).
//   Same-cycle, so the breakpointed instruction is never fetched.
//  pipe_en = 1 in RUN/STEP/DRAIN, registered.
//   Asserts the cycle after the transition edge.
//  cycle_cnt +1 in RUN/STEP/DRAIN; instr_cnt +1 when fetch_en & ~stall.
//   Both saturate at all-ones, no wrap.
// STRUCTURE
//  Package pipe_ctrl_pkg: state encodings, halt_cause codes, HALT_OP default.
//  Sub-module sat_counter #(W): clear, inc, zero-load; used for both counters.
//  Drain counter and FSM stay inline.
// TESTING
//  Run: clear 2 cyc, start 1 cyc, no stall, op never HALT_OP.
//   -> pipe_en=1 from 2nd edge; instr_cnt=10 after 10 RUN cycles.
//  Halt op: op_code=6'h3F in RUN -> kill_if 1 pulse, DRAIN.
//   -> HALTED after 3 cycles, halt_cause=11.
//  Breakpoint: bp_en=1, bp_addr=0x10, pc reaches 0x10.
//   -> fetch_en=0 same cycle; HALTED, cause 10.
//   Start again -> pc 0x10 fetched, no re-hit.
//  Step: from HALTED, pulse step with stall=1 for 2 cycles.
//   -> exactly 1 fetch (instr_cnt +1), HALTED after DRAIN.
//  Stall in drain: stall=1 for 4 cycles in DRAIN.
//   -> DRAIN length = 3 + 4 cycles.
//  Corners: start+step together in IDLE -> RUN; clear mid-DRAIN -> IDLE, counters 0.
//   Counter at all-ones stays there.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline run/step/halt sequencer.
// State and halt-cause codes are visible on the debug readout.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        HC_NONE = 2'b00,
        HC_HOST = 2'b01,
        HC_BP   = 2'b10,
        HC_OP   = 2'b11
    } halt_cause_t;

    localparam logic [5:0] HALT_OP_DEF   = 6'h3F;
    localparam int         DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and zero-load.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         zero,
    input  logic         inc,
    output logic [W-1:0] q
);

    // count up, stick at the top value
    always_ff @(posedge clk) begin
        if (clear || zero) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline.
// Gates fetch and pipeline advance, drains on halt, counts activity.
module pipe_run_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              CNT_W     = 32,
    parameter int              OP_W      = 6,
    parameter logic [OP_W-1:0] HALT_OP   = OP_W'(HALT_OP_DEF),
    parameter int              DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [OP_W-1:0]  op_code,
    input  logic             stall,
    output logic             fetch_en,
    output logic             pipe_en,
    output logic             kill_if,
    output logic             halted,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    run_state_t  st;
    halt_cause_t cause;
    logic        bp_skip;
    logic [DW-1:0] drain_cnt;
    logic        bp_hit;
    logic        halt_op;
    logic        active;
    logic        cnt_zero;

    assign bp_hit  = bp_en & (pc == bp_addr) & ~bp_skip;
    assign halt_op = (op_code == HALT_OP) & ~stall;
    assign active  = (st == ST_RUN) | (st == ST_STEP) | (st == ST_DRAIN);

    // breakpointed PC is gated off in the same cycle it is seen
    assign fetch_en = ((st == ST_RUN) & ~halt_req & ~bp_hit)
                    | (st == ST_STEP);

    assign cnt_zero   = (st == ST_IDLE) & (start | step);
    assign halted     = (st == ST_HALTED);
    assign state      = st;
    assign halt_cause = cause;

    // sequencer state, drain counter and registered pipeline controls
    always_ff @(posedge clk) begin
        if (clear) begin
            st        <= ST_IDLE;
            cause     <= HC_NONE;
            pipe_en   <= 1'b0;
            kill_if   <= 1'b0;
            bp_skip   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            pipe_en <= active;
            kill_if <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (start) begin
                        st      <= ST_RUN;
                        cause   <= HC_NONE;
                        bp_skip <= 1'b0;
                    end else if (step) begin
                        st    <= ST_STEP;
                        cause <= HC_NONE;
                    end
                end
                ST_RUN: begin
                    if (!stall) bp_skip <= 1'b0;
                    if (halt_req) begin
                        st        <= ST_DRAIN;
                        cause     <= HC_HOST;
                        drain_cnt <= '0;
                    end else if (bp_hit) begin
                        st        <= ST_DRAIN;
                        cause     <= HC_BP;
                        drain_cnt <= '0;
                    end else if (halt_op) begin
                        st        <= ST_DRAIN;
                        cause     <= HC_OP;
                        drain_cnt <= '0;
                        kill_if   <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (!stall) begin
                        st        <= ST_DRAIN;
                        cause     <= HC_NONE;
                        drain_cnt <= '0;
                    end else if (halt_req) begin
                        st        <= ST_DRAIN;
                        cause     <= HC_HOST;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            st <= ST_HALTED;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        st      <= ST_RUN;
                        cause   <= HC_NONE;
                        bp_skip <= 1'b1;
                    end else if (step) begin
                        st    <= ST_STEP;
                        cause <= HC_NONE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clear (clear),
        .zero  (cnt_zero),
        .inc   (active),
        .q     (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .clear (clear),
        .zero  (cnt_zero),
        .inc   (fetch_en & ~stall),
        .q     (instr_cnt)
    );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: directed scenarios, a behavioural
// reference checked every cycle, and literal pins on key points.
module tb_pipe_run_ctrl;

    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;

    logic          clk;
    logic          clear, start, step, halt_req, bp_en, stall;
    logic [31:0]   bp_addr, pc;
    logic [5:0]    op_code;
    logic          fetch_en, pipe_en, kill_if, halted;
    logic [2:0]    state;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    int n_chk = 0;
    int n_err = 0;

    pipe_run_ctrl #(.CNT_W(CW)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .op_code    (op_code),
        .stall      (stall),
        .fetch_en   (fetch_en),
        .pipe_en    (pipe_en),
        .kill_if    (kill_if),
        .halted     (halted),
        .state      (state),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: mode 0 idle,1 run,2 step,3 drain,4 halted
    int ms, mc, mcyc, mins, mleft;
    bit mpipe, mkill, mskip, chk_on;

    initial begin
        int ncyc, nins;
        bit bph, fe, act;
        chk_on = 0;
        ms = 0; mc = 0; mcyc = 0; mins = 0; mleft = 0;
        mpipe = 0; mkill = 0; mskip = 0;
        forever begin
            @(negedge clk);
            bph = bp_en && (pc == bp_addr) && !mskip;
            fe  = (ms == 1 && !halt_req && !bph) || ms == 2;
            act = ms >= 1 && ms <= 3;
            if (chk_on) begin
                chk("m_state", 32'(state), 32'(ms));
                chk("m_halted", 32'(halted), 32'(ms == 4));
                chk("m_cause", 32'(halt_cause), 32'(mc));
                chk("m_pipe_en", 32'(pipe_en), 32'(mpipe));
                chk("m_kill_if", 32'(kill_if), 32'(mkill));
                chk("m_fetch_en", 32'(fetch_en), 32'(fe));
                chk("m_cycle_cnt", 32'(cycle_cnt), 32'(mcyc));
                chk("m_instr_cnt", 32'(instr_cnt), 32'(mins));
            end
            ncyc = mcyc + (act ? 1 : 0);
            if (ncyc > MAX) ncyc = MAX;
            nins = mins + ((fe && !stall) ? 1 : 0);
            if (nins > MAX) nins = MAX;
            if (clear) begin
                ms = 0; mc = 0; mcyc = 0; mins = 0;
                mpipe = 0; mkill = 0; mskip = 0;
                chk_on = 1;
            end else begin
                mpipe = act;
                mkill = 0;
                mcyc  = ncyc;
                mins  = nins;
                case (ms)
                    0: if (start) begin
                        ms = 1; mc = 0; mcyc = 0; mins = 0; mskip = 0;
                    end else if (step) begin
                        ms = 2; mc = 0; mcyc = 0; mins = 0;
                    end
                    1: begin
                        if (!stall) mskip = 0;
                        if (halt_req) begin
                            ms = 3; mc = 1; mleft = 3;
                        end else if (bph) begin
                            ms = 3; mc = 2; mleft = 3;
                        end else if (op_code == 6'h3F && !stall) begin
                            ms = 3; mc = 3; mleft = 3; mkill = 1;
                        end
                    end
                    2: if (!stall) begin
                        ms = 3; mc = 0; mleft = 3;
                    end else if (halt_req) begin
                        ms = 3; mc = 1; mleft = 3;
                    end
                    3: if (!stall) begin
                        mleft--;
                        if (mleft == 0) ms = 4;
                    end
                    4: if (start) begin
                        ms = 1; mc = 0; mskip = 1;
                    end else if (step) begin
                        ms = 2; mc = 0;
                    end
                    default: ms = 0;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ins0, dcnt;
        clear = 1; start = 0; step = 0; halt_req = 0;
        bp_en = 0; bp_addr = 32'h10; pc = 32'h100;
        op_code = 6'h00; stall = 0;
        cyc();
        cyc();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pipe_en", 32'(pipe_en), 32'd0);
        chk("reset_instr", 32'(instr_cnt), 32'd0);

        // plain run
        clear = 0; start = 1;
        cyc();
        start = 0;
        chk("run_enter", 32'(state), 32'd1);
        chk("run_pipe_lag", 32'(pipe_en), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            pc = pc + 4;
        end
        chk("run_pipe_en", 32'(pipe_en), 32'd1);
        chk("run_instr10", 32'(instr_cnt), 32'd10);
        chk("run_cyc10", 32'(cycle_cnt), 32'd10);

        // HALT opcode in decode
        op_code = 6'h3F;
        cyc();
        op_code = 6'h00;
        chk("hop_drain", 32'(state), 32'd3);
        chk("hop_kill", 32'(kill_if), 32'd1);
        cyc();
        chk("hop_kill_pulse", 32'(kill_if), 32'd0);
        cyc();
        cyc();
        chk("hop_halted", 32'(halted), 32'd1);
        chk("hop_cause", 32'(halt_cause), 32'd3);

        // breakpoint at 0x10
        bp_en = 1; pc = 32'h0C; start = 1;
        cyc();
        start = 0;
        cyc();
        pc = 32'h10;
        #1;
        chk("bp_fetch_gated", 32'(fetch_en), 32'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("bp_halted", 32'(state), 32'd4);
        chk("bp_cause", 32'(halt_cause), 32'd2);
        ins0 = int'(instr_cnt);
        start = 1;
        cyc();
        start = 0;
        #1;
        chk("bp_resume_fetch", 32'(fetch_en), 32'd1);
        cyc();
        pc = 32'h14;
        chk("bp_no_rehit", 32'(state), 32'd1);
        chk("bp_resume_cnt", 32'(instr_cnt), 32'(ins0 + 1));
        cyc();
        halt_req = 1;
        cyc();
        halt_req = 0;
        chk("host_cause", 32'(halt_cause), 32'd1);
        repeat (3) cyc();
        bp_en = 0;

        // single step under stall
        ins0 = int'(instr_cnt);
        step = 1; stall = 1;
        cyc();
        step = 0;
        chk("step_enter", 32'(state), 32'd2);
        cyc();
        cyc();
        stall = 0;
        cyc();
        chk("step_drain", 32'(state), 32'd3);
        repeat (3) cyc();
        chk("step_halted", 32'(state), 32'd4);
        chk("step_one_fetch", 32'(instr_cnt), 32'(ins0 + 1));
        chk("step_cause", 32'(halt_cause), 32'd0);

        // stalls stretch the drain
        start = 1;
        cyc();
        start = 0;
        cyc();
        halt_req = 1;
        cyc();
        halt_req = 0;
        dcnt = 0;
        for (int i = 0; i < 20 && state == 3'd3; i++) begin
            dcnt++;
            stall = (dcnt <= 4);
            cyc();
        end
        stall = 0;
        chk("drain_len", 32'(dcnt), 32'd7);
        chk("drain_halted", 32'(state), 32'd4);

        // corners: start+step in idle, clear mid-drain
        clear = 1;
        cyc();
        clear = 0; halt_req = 1;
        cyc();
        chk("idle_ignore_halt", 32'(state), 32'd0);
        halt_req = 0; start = 1; step = 1;
        cyc();
        start = 0; step = 0;
        chk("start_wins", 32'(state), 32'd1);
        halt_req = 1;
        cyc();
        halt_req = 0;
        cyc();
        clear = 1;
        cyc();
        clear = 0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_cyc", 32'(cycle_cnt), 32'd0);
        chk("clr_instr", 32'(instr_cnt), 32'd0);

        // saturation
        start = 1;
        cyc();
        start = 0;
        repeat (70) cyc();
        chk("sat_cyc", 32'(cycle_cnt), 32'(MAX));
        chk("sat_instr", 32'(instr_cnt), 32'(MAX));
        halt_req = 1;
        cyc();
        halt_req = 0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
